// File: rtl/mem_dados_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_dados_pkg
//  Description : Shared definitions for the data-memory responder: funct3
//                access codes, FSM state type and byte-enable helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_dados_pkg;

    // funct3 access size/sign codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Byte lanes touched by an access of the given size (funct3[1:0]) at the
    // given byte offset within the word.
    function automatic logic [3:0] byte_enable(input logic [1:0] size,
                                               input logic [1:0] offset);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << offset;
            2'b01:   be = offset[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane_align
//  Description : Combinational lane steering. Extracts and sign/zero-extends
//                load data from the read word, and replicates store data onto
//                every lane with the matching byte enables.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import mem_dados_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] write_word,
    output logic [3:0]  byte_en
);

    logic [31:0] shifted;

    // Select the addressed lane, extend it, and build the store word/enables
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   load_data = {24'd0, shifted[7:0]};
            F3_HU:   load_data = {16'd0, shifted[15:0]};
            default: load_data = rdata;
        endcase

        case (funct3[1:0])
            2'b00:   write_word = {4{wdata[7:0]}};
            2'b01:   write_word = {2{wdata[15:0]}};
            default: write_word = wdata;
        endcase

        byte_en = byte_enable(funct3[1:0], offset);
    end

endmodule
`default_nettype wire

// File: rtl/mem_dados_resp.sv
`default_nettype none
// ============================================================================
//  Module      : mem_dados_resp
//  Description : Data-memory responder for the load/store port. One request
//                at a time over valid/ready, WAIT_STATES idle cycles, byte/
//                halfword/word access on a word-organised RAM, error flag.
//                Optional macro MEM_DADOS_ALIGN_CHECK_EN: report misaligned
//                halfword/word accesses as errors instead of force-aligning.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_dados_resp
    import mem_dados_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iReq,
    input  logic [31:0] iEnd,
    input  logic [31:0] iDadoEscrita,
    input  logic        iEscMem,
    input  logic        iLeMem,
    input  logic [2:0]  iFunct3,
    output logic        oPronto,
    output logic        oValido,
    output logic [31:0] oDado,
    output logic        oErro
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

    state_t      state, state_next;
    logic [3:0]  wait_cnt, wait_cnt_next;

    logic [31:0] cap_addr, cap_wdata;
    logic        cap_store, cap_load;
    logic [2:0]  cap_funct3;

    logic [31:0] req_addr, req_wdata;
    logic        req_store, req_load;
    logic [2:0]  req_funct3;

    logic        funct3_bad, op_bad, range_bad, misalign, req_err;
    logic [1:0]  offset;
    logic        enter_resp, do_write;

    logic [31:0] ram [0:(2**ADDR_WIDTH)-1];
    logic [31:0] rdata, load_data, write_word;
    logic [3:0]  byte_en;

    // In IDLE the live inputs are the request (needed when WAIT_STATES=0 and
    // RESP is entered on the accept edge); afterwards the captured copy is.
    always_comb begin
        if (state == IDLE) begin
            req_addr   = iEnd;
            req_wdata  = iDadoEscrita;
            req_store  = iEscMem;
            req_load   = iLeMem;
            req_funct3 = iFunct3;
        end else begin
            req_addr   = cap_addr;
            req_wdata  = cap_wdata;
            req_store  = cap_store;
            req_load   = cap_load;
            req_funct3 = cap_funct3;
        end
    end

    // Error classification and effective byte offset of the access
    always_comb begin
        op_bad    = (req_store == req_load);
        range_bad = |req_addr[31:ADDR_WIDTH+2];
        case (req_funct3)
            F3_B, F3_H, F3_W: funct3_bad = 1'b0;
            F3_BU, F3_HU:     funct3_bad = req_store;
            default:          funct3_bad = 1'b1;
        endcase
`ifdef MEM_DADOS_ALIGN_CHECK_EN
        misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        offset   = req_addr[1:0];
`else
        misalign = 1'b0;
        case (req_funct3[1:0])
            2'b01:   offset = {req_addr[1], 1'b0};
            2'b10:   offset = 2'b00;
            default: offset = req_addr[1:0];
        endcase
`endif
        req_err = op_bad | range_bad | funct3_bad | misalign;
    end

    assign rdata = ram[req_addr[ADDR_WIDTH+1:2]];

    mem_lane_align u_lane_align (
        .rdata      (rdata),
        .offset     (offset),
        .funct3     (req_funct3),
        .wdata      (req_wdata),
        .load_data  (load_data),
        .write_word (write_word),
        .byte_en    (byte_en)
    );

    // Next-state, wait counter and ready output
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        oPronto       = (state == IDLE);
        case (state)
            IDLE: begin
                if (iReq) begin
                    wait_cnt_next = 4'd0;
                    state_next    = (WAIT_STATES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    wait_cnt_next = 4'd0;
                    state_next    = RESP;
                end else begin
                    wait_cnt_next = wait_cnt + 4'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign enter_resp = (state_next == RESP) && !iRST;
    assign do_write   = enter_resp && req_store && !req_err;

    // State register; reset aborts any request in flight
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Capture the request fields on the accept edge
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            cap_addr   <= 32'd0;
            cap_wdata  <= 32'd0;
            cap_store  <= 1'b0;
            cap_load   <= 1'b0;
            cap_funct3 <= 3'd0;
        end else if (iReq && (state == IDLE)) begin
            cap_addr   <= iEnd;
            cap_wdata  <= iDadoEscrita;
            cap_store  <= iEscMem;
            cap_load   <= iLeMem;
            cap_funct3 <= iFunct3;
        end
    end

    // Response registers, loaded on the edge entering RESP; oDado holds after
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oValido <= 1'b0;
            oDado   <= 32'd0;
            oErro   <= 1'b0;
        end else begin
            oValido <= enter_resp;
            if (enter_resp) begin
                oErro <= req_err;
                oDado <= (req_load && !req_err) ? load_data : 32'd0;
            end
        end
    end

    // RAM byte-lane write, committed on the edge entering RESP
    always_ff @(posedge iCLK) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    ram[req_addr[ADDR_WIDTH+1:2]][8*i +: 8] <= write_word[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_dados_resp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_dados_resp
//  Description : Self-checking bench for mem_dados_resp with a byte-array
//                reference model; directed and randomized requests.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_dados_resp;

    localparam int AW = 10;
    localparam int WS = 1;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iReq = 1'b0;
    logic [31:0] iEnd = 32'd0;
    logic [31:0] iDadoEscrita = 32'd0;
    logic        iEscMem = 1'b0;
    logic        iLeMem = 1'b0;
    logic [2:0]  iFunct3 = 3'd0;
    logic        oPronto, oValido, oErro;
    logic [31:0] oDado;

    int checks = 0;
    int errors = 0;

    logic [7:0] mdl [0:4095];

    mem_dados_resp #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
        .iCLK(iCLK), .iRST(iRST), .iReq(iReq), .iEnd(iEnd),
        .iDadoEscrita(iDadoEscrita), .iEscMem(iEscMem), .iLeMem(iLeMem),
        .iFunct3(iFunct3), .oPronto(oPronto), .oValido(oValido),
        .oDado(oDado), .oErro(oErro)
    );

    always #5 iCLK = ~iCLK;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    // Reference: byte-addressed memory with the access rules applied directly
    task automatic model_access(input bit st, input bit ld, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] d, output bit e);
        int n;
        int ea;
        logic [31:0] v;
        e = 0;
        d = 0;
        if (st == ld) e = 1;
        if (f3 == 3'd3 || f3 > 3'd5) e = 1;
        if (st && f3 >= 3'd4) e = 1;
        if ((a >> 2) >= (32'd1 << AW)) e = 1;
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
`ifdef MEM_DADOS_ALIGN_CHECK_EN
        if ((a % n) != 0) e = 1;
        ea = int'(a % 4096);
`else
        ea = int'((a - (a % n)) % 4096);
`endif
        if (!e) begin
            if (st) begin
                for (int i = 0; i < n; i++) mdl[ea+i] = wd[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < n; i++) v = v | (32'(mdl[ea+i]) << (8*i));
                if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
                if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
                d = v;
            end
        end
    endtask

    // Issue one request (caller at a negedge) and wait for its response
    task automatic do_req(input bit st, input bit ld, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] d, output logic e,
                          output int lat, output bit ok);
        int guard = 0;
        while (!oPronto && guard < 50) begin
            @(negedge iCLK);
            guard++;
        end
        iReq = 1; iEscMem = st; iLeMem = ld; iFunct3 = f3; iEnd = a; iDadoEscrita = wd;
        @(posedge iCLK);
        lat = 1;
        @(negedge iCLK);
        iReq = 0;
        while (!oValido && lat < 50) begin
            @(posedge iCLK);
            lat++;
            @(negedge iCLK);
        end
        ok = oValido;
        d  = oDado;
        e  = oErro;
    endtask

    task automatic check_req(input string nm, input bit st, input bit ld,
                             input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input bit use_lit,
                             input logic [31:0] lit_d, input bit lit_e);
        logic [31:0] exp_d, d;
        bit exp_e;
        logic e;
        int lat;
        bit ok;
        model_access(st, ld, f3, a, wd, exp_d, exp_e);
        do_req(st, ld, f3, a, wd, d, e, lat, ok);
        checks++;
        if (!ok) begin
            $display("FAIL %s no_response after %0d cycles", nm, lat);
            errors++;
            return;
        end
        checks++;
        if (lat !== WS + 1) begin
            $display("FAIL %s latency got %0d exp %0d", nm, lat, WS + 1);
            errors++;
        end
        checks++;
        if (e !== exp_e) begin
            $display("FAIL %s erro got %0b exp %0b", nm, e, exp_e);
            errors++;
        end
        checks++;
        if (d !== exp_d) begin
            $display("FAIL %s dado got %08h exp %08h", nm, d, exp_d);
            errors++;
        end
        if (use_lit) begin
            checks++;
            if (d !== lit_d || e !== lit_e) begin
                $display("FAIL %s literal got %08h/%0b exp %08h/%0b", nm, d, e, lit_d, lit_e);
                errors++;
            end
        end
        @(negedge iCLK);
        checks++;
        if (oValido !== 1'b0 || oPronto !== 1'b1) begin
            $display("FAIL %s after_resp valido/pronto got %0b/%0b exp 0/1", nm, oValido, oPronto);
            errors++;
        end
    endtask

    task automatic test_reset();
        iRST = 1;
        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        checks++;
        if (oPronto !== 1'b1 || oValido !== 1'b0 || oDado !== 32'd0 || oErro !== 1'b0) begin
            $display("FAIL reset got pronto=%0b valido=%0b dado=%08h erro=%0b exp 1/0/0/0",
                     oPronto, oValido, oDado, oErro);
            errors++;
        end
        iRST = 0;
        @(negedge iCLK);
    endtask

    task automatic test_init();
        for (int w = 0; w < 16; w++)
            check_req("init_sw", 1, 0, 3'b010, 32'(4*w), $urandom, 0, 0, 0);
    endtask

    task automatic test_directed();
        check_req("sw_10",  1, 0, 3'b010, 32'h10, 32'hDEADBEEF, 1, 32'h0, 0);
        check_req("lw_10",  0, 1, 3'b010, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0);
        check_req("lb_13",  0, 1, 3'b000, 32'h13, 32'h0, 1, 32'hFFFFFFDE, 0);
        check_req("lbu_13", 0, 1, 3'b100, 32'h13, 32'h0, 1, 32'h000000DE, 0);
        check_req("lh_12",  0, 1, 3'b001, 32'h12, 32'h0, 1, 32'hFFFFDEAD, 0);
        check_req("lhu_10", 0, 1, 3'b101, 32'h10, 32'h0, 1, 32'h0000BEEF, 0);
        check_req("sb_11",  1, 0, 3'b000, 32'h11, 32'h00000055, 1, 32'h0, 0);
        check_req("lw_sb",  0, 1, 3'b010, 32'h10, 32'h0, 1, 32'hDEAD55EF, 0);
        check_req("sh_12",  1, 0, 3'b001, 32'h12, 32'h00001234, 1, 32'h0, 0);
        check_req("lw_sh",  0, 1, 3'b010, 32'h10, 32'h0, 1, 32'h123455EF, 0);
    endtask

    task automatic test_misalign();
`ifdef MEM_DADOS_ALIGN_CHECK_EN
        check_req("lw_11_err", 0, 1, 3'b010, 32'h11, 32'h0, 1, 32'h0, 1);
        check_req("sw_11_err", 1, 0, 3'b010, 32'h11, 32'hFFFFFFFF, 1, 32'h0, 1);
`else
        check_req("lw_11_aln", 0, 1, 3'b010, 32'h11, 32'h0, 1, 32'h123455EF, 0);
`endif
        check_req("lw_10_chk", 0, 1, 3'b010, 32'h10, 32'h0, 1, 32'h123455EF, 0);
    endtask

    task automatic test_errors();
        check_req("both_set",  1, 1, 3'b010, 32'h10, 32'h11111111, 1, 32'h0, 1);
        check_req("neither",   0, 0, 3'b010, 32'h10, 32'h22222222, 1, 32'h0, 1);
        check_req("f3_011",    0, 1, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1);
        check_req("sbu_store", 1, 0, 3'b100, 32'h10, 32'h33333333, 1, 32'h0, 1);
        check_req("addr_1000", 1, 0, 3'b010, 32'h1000, 32'h44444444, 1, 32'h0, 1);
        check_req("lw_intact", 0, 1, 3'b010, 32'h10, 32'h0, 1, 32'h123455EF, 0);
        check_req("lw_0_intact", 0, 1, 3'b010, 32'h0, 32'h0, 0, 0, 0);
    endtask

    // Request held through WAIT must be accepted only once; oDado then holds
    task automatic test_hold();
        logic [31:0] exp_d, got;
        bit exp_e;
        int lat = 0;
        int extra = 0;
        model_access(0, 1, 3'b010, 32'h14, 32'h0, exp_d, exp_e);
        iReq = 1; iEscMem = 0; iLeMem = 1; iFunct3 = 3'b010; iEnd = 32'h14;
        do begin
            @(posedge iCLK);
            @(negedge iCLK);
            lat++;
            if (!oValido) begin
                checks++;
                if (oPronto !== 1'b0) begin
                    $display("FAIL hold_pronto got %0b exp 0", oPronto);
                    errors++;
                end
            end
        end while (!oValido && lat < 50);
        got = oDado;
        iReq = 0;
        checks++;
        if (got !== exp_d || oErro !== exp_e) begin
            $display("FAIL hold_data got %08h/%0b exp %08h/%0b", got, oErro, exp_d, exp_e);
            errors++;
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge iCLK);
            if (oValido) extra++;
        end
        checks++;
        if (extra !== 0) begin
            $display("FAIL hold_double_accept got %0d extra pulses exp 0", extra);
            errors++;
        end
        checks++;
        if (oDado !== got) begin
            $display("FAIL dado_hold got %08h exp %08h", oDado, got);
            errors++;
        end
    endtask

    // Store aborted by reset after accept: no pulse, no write
    task automatic test_abort();
        int pulses = 0;
        iReq = 1; iEscMem = 1; iLeMem = 0; iFunct3 = 3'b010; iEnd = 32'h10;
        iDadoEscrita = 32'hCAFEF00D;
        @(posedge iCLK);
        @(negedge iCLK);
        iReq = 0;
        iRST = 1;
        if (oValido) pulses++;
        @(posedge iCLK);
        @(negedge iCLK);
        iRST = 0;
        checks++;
        if (oPronto !== 1'b1) begin
            $display("FAIL abort_pronto got %0b exp 1", oPronto);
            errors++;
        end
        for (int i = 0; i < 5; i++) begin
            if (oValido) pulses++;
            @(negedge iCLK);
        end
        checks++;
        if (pulses !== 0) begin
            $display("FAIL abort_valido got %0d pulses exp 0", pulses);
            errors++;
        end
        check_req("lw_after_abort", 0, 1, 3'b010, 32'h10, 32'h0, 1, 32'h123455EF, 0);
    endtask

    task automatic test_random();
        bit st, ld;
        logic [2:0] f3;
        logic [31:0] a;
        int kind;
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 9);
            st = 1'($urandom_range(0, 1));
            ld = !st;
            if (kind == 0) begin st = 1; ld = 1; end
            if (kind == 1) begin st = 0; ld = 0; end
            f3 = 3'($urandom_range(0, 7));
            a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0000_1000;
            check_req("random", st, ld, f3, a, $urandom, 0, 0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_directed();
        test_misalign();
        test_errors();
        test_hold();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
